mmio_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter; sits on the single-cycle core's data-memory bus as a responder, beside data_memory.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/mmio_uart_tx_if.sv | 27 ++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/mmio_uart_tx.sv | 216 +++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS bit positions, serialiser state encoding and the
// minimum legal baud divisor.
package uart_pkg;

    // Word offsets inside the register window (addr[1:0] ignored)
    localparam logic [3:0] UART_TXDATA = 4'h0;
    localparam logic [3:0] UART_STATUS = 4'h4;
    localparam logic [3:0] UART_BAUD   = 4'h8;

    // STATUS bit positions
    localparam int ST_BUSY     = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_EMPTY    = 2;
    localparam int ST_OVERFLOW = 3;
    localparam int ST_COUNT_LO = 4;

    // Smallest divisor the serialiser can run with
    localparam logic [15:0] BAUD_MIN = 16'd2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // Divisors below BAUD_MIN are raised to BAUD_MIN
    function automatic logic [15:0] clamp_baud(input logic [15:0] value);
        return (value < BAUD_MIN) ? BAUD_MIN : value;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus as seen by an MMIO responder: address, store data and
// strobe from the core; combinational load data and window hit back.
interface mmio_uart_tx_if #(
    parameter int BUS_WIDTH = 32
);
    logic [BUS_WIDTH-1:0] addr;
    logic [BUS_WIDTH-1:0] write_data;
    logic                 write_en;
    logic [BUS_WIDTH-1:0] read_data;
    logic                 hit;

    modport master (
        output addr,
        output write_data,
        output write_en,
        input  read_data,
        input  hit
    );

    modport slave (
        input  addr,
        input  write_data,
        input  write_en,
        output read_data,
        output hit
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output. A push into a full
// FIFO is dropped even when a pop happens in the same cycle; push and pop
// together on a non-full FIFO leave the count unchanged.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Next occupancy from the accepted push/pop pair
    always_comb begin
        count_d = count;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count + CW'(1);
            2'b01:   count_d = count - CW'(1);
            default: count_d = count;
        endcase
    end

    // Pointer and occupancy state; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_d;
        end
    end

    // Storage array, data only
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter. The core stores bytes into a TX
// FIFO through TXDATA; the serialiser drains it LSB-first at the divisor
// held in BAUD. Loads are combinational, stores commit on the clock edge.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int                   BUS_WIDTH    = 32,
    parameter logic [BUS_WIDTH-1:0] BASE_ADDR    = 'h3000,
    parameter int                   FIFO_DEPTH   = 4,
    parameter logic [15:0]          CLKS_PER_BIT = 16'd434
) (
    input  logic          clk,
    input  logic          rst,
    mmio_uart_tx_if.slave bus,
    output logic          tx,
    output logic          busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // ---------------- address decode ----------------
    logic [BUS_WIDTH-1:0] offset;
    logic                 in_window;
    logic [3:0]           word_off;
    logic                 wr_txdata;
    logic                 wr_status;
    logic                 wr_baud;

    assign offset    = bus.addr - BASE_ADDR;
    assign in_window = (offset < BUS_WIDTH'(12));
    assign word_off  = {offset[3:2], 2'b00};
    assign wr_txdata = bus.write_en && in_window && (word_off == UART_TXDATA);
    assign wr_status = bus.write_en && in_window && (word_off == UART_STATUS);
    assign wr_baud   = bus.write_en && in_window && (word_off == UART_BAUD);
    assign bus.hit   = in_window;

    logic unused_wdata;
    assign unused_wdata = ^bus.write_data[BUS_WIDTH-1:16];

    // ---------------- TX FIFO ----------------
    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_txdata),
        .din   (bus.write_data[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // ---------------- register file ----------------
    logic [15:0] baud_q;
    logic        overflow_q;

    // BAUD divisor and sticky overflow flag; reset wins over any store
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_q     <= clamp_baud(CLKS_PER_BIT);
            overflow_q <= 1'b0;
        end else begin
            if (wr_baud) baud_q <= clamp_baud(bus.write_data[15:0]);
            if (wr_txdata && fifo_full)
                overflow_q <= 1'b1;
            else if (wr_status && bus.write_data[ST_OVERFLOW])
                overflow_q <= 1'b0;
        end
    end

    // Four-bit count field saturates if a deeper FIFO is configured
    logic [31:0] count_wide;
    logic [3:0]  count_field;
    assign count_wide  = 32'(fifo_count);
    assign count_field = (count_wide > 32'd15) ? 4'hF : count_wide[3:0];

    function automatic logic [7:0] status_byte(
        input logic       b,
        input logic       f,
        input logic       e,
        input logic       o,
        input logic [3:0] c
    );
        logic [7:0] s;
        s                          = '0;
        s[ST_BUSY]                 = b;
        s[ST_FULL]                 = f;
        s[ST_EMPTY]                = e;
        s[ST_OVERFLOW]             = o;
        s[ST_COUNT_LO+3:ST_COUNT_LO] = c;
        return s;
    endfunction

    // Same-cycle load path; zero outside the window and for TXDATA
    always_comb begin
        bus.read_data = '0;
        if (in_window) begin
            case (word_off)
                UART_STATUS: bus.read_data[7:0]  = status_byte(busy, fifo_full, fifo_empty,
                                                               overflow_q, count_field);
                UART_BAUD:   bus.read_data[15:0] = baud_q;
                default:     bus.read_data       = '0;
            endcase
        end
    end

    // ---------------- serialiser ----------------
    tx_state_e   state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic        tx_q, tx_d;
    logic        bit_done;
    logic        load_frame;

    assign bit_done = (cnt_q == div_q - 16'd1);
    assign tx       = tx_q;
    assign busy     = (state_q != TX_IDLE) || !fifo_empty;

    // Next-state logic; a new frame is loaded from IDLE or straight out of STOP
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bitcnt_d   = bitcnt_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        tx_d       = tx_q;
        load_frame = 1'b0;

        case (state_q)
            TX_IDLE: begin
                load_frame = !fifo_empty;
            end
            TX_START: begin
                if (bit_done) begin
                    cnt_d    = '0;
                    tx_d     = shift_q[0];
                    shift_d  = {1'b0, shift_q[7:1]};
                    bitcnt_d = '0;
                    state_d  = TX_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            TX_DATA: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (bitcnt_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        tx_d     = shift_q[0];
                        shift_d  = {1'b0, shift_q[7:1]};
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            TX_STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (!fifo_empty) load_frame = 1'b1;
                    else             state_d    = TX_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = TX_IDLE;
        endcase

        // Divisor is captured here so BAUD stores never disturb a frame in flight
        if (load_frame) begin
            shift_d  = fifo_dout;
            div_d    = baud_q;
            tx_d     = 1'b0;
            cnt_d    = '0;
            bitcnt_d = '0;
            state_d  = TX_START;
        end
    end

    assign fifo_pop = load_frame;

    // Serialiser control state, reset to an idle-high line
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= TX_IDLE;
            tx_q     <= 1'b1;
            cnt_q    <= '0;
            bitcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    // Frame data registers, loaded only when a frame starts or shifts
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        div_q   <= div_d;
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed bus stores/loads, with a scoreboard of
// expected serial frames checked bit-by-bit by an independent line monitor.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h3000;
    localparam logic [31:0] A_TXDATA = BASE + 32'h0;
    localparam logic [31:0] A_STATUS = BASE + 32'h4;
    localparam logic [31:0] A_BAUD   = BASE + 32'h8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    logic busy;

    mmio_uart_tx_if #(.BUS_WIDTH(32)) bus ();

    mmio_uart_tx #(
        .BUS_WIDTH    (32),
        .BASE_ADDR    (BASE),
        .FIFO_DEPTH   (4),
        .CLKS_PER_BIT (16'd434)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .tx   (tx),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         div;
        int         ncyc;
        bit         contig;
    } frame_t;

    frame_t sb[$];
    int     tests = 0;
    int     fails = 0;
    bit     mon_go = 1'b0;

    // ---------------- scoreboard monitor ----------------
    function automatic logic exp_bit(input frame_t f, input int c);
        int idx;
        idx = c / f.div;
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return f.data[idx-1];
    endfunction

    initial begin : monitor
        frame_t f;
        int     gap;
        int     errs;
        int     bad_c;
        logic   bad_v;
        wait (mon_go);
        gap = 1000;
        forever begin
            @(negedge clk);
            if (tx !== 1'b0) begin
                gap++;
            end else if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_frame: tx fell with no frame expected at %0t", $time);
                while (tx === 1'b0) @(negedge clk);
                gap = 0;
            end else begin
                f = sb.pop_front();
                if (f.contig) begin
                    tests++;
                    if (gap != 0) begin
                        fails++;
                        $display("FAIL frame_gap data=%02h: idle cycles %0d, required 0", f.data, gap);
                    end
                end
                errs  = 0;
                bad_c = -1;
                bad_v = 1'b0;
                for (int c = 0; c < f.ncyc; c++) begin
                    if (c > 0) @(negedge clk);
                    if (tx !== exp_bit(f, c)) begin
                        if (errs == 0) begin
                            bad_c = c;
                            bad_v = tx;
                        end
                        errs++;
                    end
                end
                tests++;
                if (errs != 0) begin
                    fails++;
                    $display("FAIL frame data=%02h div=%0d: cycle %0d tx=%b, required %b (%0d bad cycles)",
                             f.data, f.div, bad_c, bad_v, exp_bit(f, bad_c), errs);
                end
                gap = 0;
            end
        end
    end

    // ---------------- bus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr       = a;
        bus.write_data = d;
        bus.write_en   = 1'b1;
        @(posedge clk);
        #1;
        bus.write_en   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h);
        bus.write_en = 1'b0;
        bus.addr     = a;
        #1;
        d = bus.read_data;
        h = bus.hit;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h, required %08h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input int max, output int n);
        n = 0;
        while (busy === 1'b1 && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input int div, input int ncyc, input bit contig);
        frame_t f;
        f.data   = d;
        f.div    = div;
        f.ncyc   = ncyc;
        f.contig = contig;
        sb.push_back(f);
    endtask

    // Overall time limit
    initial begin : watchdog
        #(10 * 20000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin : stim
        logic [31:0] d;
        logic        h;
        int          n;

        bus.addr       = '0;
        bus.write_data = '0;
        bus.write_en   = 1'b0;
        rst            = 1'b1;
        tick(2);
        rst = 1'b0;
        mon_go = 1'b1;

        // Reset state
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rd(A_STATUS, d, h);
        check("rst_status", d, 32'h04);
        check("rst_status_hit", 32'(h), 32'd1);
        rd(A_BAUD, d, h);
        check("rst_baud", d, 32'd434);

        // 1: single byte 0xA5 at divisor 4
        wr(A_BAUD, 32'd4);
        expect_frame(8'hA5, 4, 40, 1'b0);
        wr(A_TXDATA, 32'hA5);
        check("t1_tx_before_start", 32'(tx), 32'd1);
        check("t1_busy_after_store", 32'(busy), 32'd1);
        tick(1);
        check("t1_tx_start", 32'(tx), 32'd0);
        wait_idle(100, n);
        check("t1_busy_cycles", 32'(n), 32'd40);
        check("t1_tx_idle", 32'(tx), 32'd1);

        // 2: five back-to-back stores, then overflow
        tick(3);
        expect_frame(8'h11, 4, 40, 1'b0);
        expect_frame(8'h22, 4, 40, 1'b1);
        expect_frame(8'h33, 4, 40, 1'b1);
        expect_frame(8'h44, 4, 40, 1'b1);
        expect_frame(8'h55, 4, 40, 1'b1);
        wr(A_TXDATA, 32'h11);
        wr(A_TXDATA, 32'h22);
        wr(A_TXDATA, 32'h33);
        wr(A_TXDATA, 32'h44);
        wr(A_TXDATA, 32'h55);
        rd(A_STATUS, d, h);
        check("t2_status_full", d, 32'h43);
        wr(A_TXDATA, 32'h66);
        rd(A_STATUS, d, h);
        check("t2_status_overflow", d, 32'h4B);
        wr(A_STATUS, 32'h08);
        rd(A_STATUS, d, h);
        check("t2_status_cleared", d, 32'h43);
        wait_idle(400, n);
        check("t2_drain", 32'(busy), 32'd0);
        rd(A_STATUS, d, h);
        check("t2_status_idle", d, 32'h04);

        // 3: divisor clamp and mid-frame divisor change
        tick(3);
        wr(A_BAUD, 32'd0);
        rd(A_BAUD, d, h);
        check("t3_baud_clamp", d, 32'd2);
        wr(A_BAUD, 32'h0001_0001);
        rd(A_BAUD, d, h);
        check("t3_baud_clamp_upper", d, 32'd2);
        wr(A_BAUD, 32'd4);
        expect_frame(8'h3C, 4, 40, 1'b0);
        expect_frame(8'hC3, 8, 80, 1'b1);
        wr(A_TXDATA, 32'h3C);
        wr(A_TXDATA, 32'hC3);
        tick(5);
        wr(A_BAUD, 32'd8);
        rd(A_BAUD, d, h);
        check("t3_baud_8", d, 32'd8);
        wait_idle(400, n);
        check("t3_drain", 32'(busy), 32'd0);

        // 4: decode boundaries
        tick(2);
        rd(A_STATUS, d, h);
        check("t4_status_idle", d, 32'h04);
        rd(A_TXDATA, d, h);
        check("t4_txdata_read", d, 32'h0);
        check("t4_txdata_hit", 32'(h), 32'd1);
        rd(BASE + 32'hC, d, h);
        check("t4_past_window_hit", 32'(h), 32'd0);
        check("t4_past_window_data", d, 32'h0);
        rd(32'h2000, d, h);
        check("t4_below_window_hit", 32'(h), 32'd0);
        check("t4_below_window_data", d, 32'h0);
        wr(32'h2000, 32'h55);
        tick(3);
        rd(A_STATUS, d, h);
        check("t4_store_outside", d, 32'h04);
        check("t4_tx_quiet", 32'(tx), 32'd1);

        // 5: reset in the middle of data bit 3, with a store on the reset cycle
        wr(A_BAUD, 32'd4);
        expect_frame(8'h5A, 4, 17, 1'b0);
        wr(A_TXDATA, 32'h5A);
        tick(17);
        rst            = 1'b1;
        bus.addr       = A_TXDATA;
        bus.write_data = 32'h77;
        bus.write_en   = 1'b1;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.write_en = 1'b0;
        check("t5_tx_after_rst", 32'(tx), 32'd1);
        check("t5_busy_after_rst", 32'(busy), 32'd0);
        rd(A_STATUS, d, h);
        check("t5_status_after_rst", d, 32'h04);
        rd(A_BAUD, d, h);
        check("t5_baud_after_rst", d, 32'd434);
        tick(20);
        check("t5_tx_still_idle", 32'(tx), 32'd1);

        tick(10);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
